// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package muldiv_pkg;
  localparam int MD_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MFHI  = 3'b100,
    OP_MFLO  = 3'b101,
    OP_MTHI  = 3'b110,
    OP_MTLO  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  localparam logic [MD_WIDTH-1:0] DIV0_QUOT = {MD_WIDTH{1'b1}};
endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring shift-subtract divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               div_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               qbit_o
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;

  always_comb begin
    sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // Divide: acc = {remainder, dividend bits still to shift in}
    trial  = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_i};
    qbit_o = div_i & ~trial[WIDTH];
    if (div_i)
      acc_o = {(qbit_o ? trial[WIDTH-1:0] : acc_i[2*WIDTH-2:WIDTH-1]),
               acc_i[WIDTH-2:0], 1'b0};
    else
      acc_o = {sum, acc_i[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/DIV sequencer owning HI/LO; stalls EX while iterating.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A_input,
  input  logic [WIDTH-1:0] B_input,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               div_q, neg_lo_q, neg_hi_q, div0_q;
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               accept, signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] step_acc, acc_d, prod;
  logic               step_q;
  logic [WIDTH-1:0]   quot, rem;

  assign accept    = start && (state_q == S_IDLE);
  assign signed_op = ~op[0] & ~op[2];
  assign a_neg     = signed_op & A_input[WIDTH-1];
  assign b_neg     = signed_op & B_input[WIDTH-1];
  assign a_mag     = a_neg ? -A_input : A_input;
  assign b_mag     = b_neg ? -B_input : B_input;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .div_i  (div_q),
    .acc_o  (step_acc),
    .qbit_o (step_q)
  );

  assign acc_d = div_q ? {step_acc[2*WIDTH-1:1], step_q} : step_acc;
  assign prod  = neg_lo_q ? -acc_q : acc_q;
  // Zero divisor leaves remainder = dividend; quotient is forced to all ones
  assign quot  = div0_q ? WIDTH'(DIV0_QUOT)
               : (neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign rem   = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          if (!op[2]) begin
            state_q  <= S_RUN;
            busy_q   <= 1'b1;
            cnt_q    <= CW'(WIDTH-1);
            acc_q    <= {{WIDTH{1'b0}}, a_mag};
            opnd_q   <= b_mag;
            div_q    <= op[1];
            div0_q   <= op[1] && (B_input == '0);
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= op[1] & a_neg;
          end else if (op[1]) begin
            if (op[0]) lo_q <= A_input;
            else       hi_q <= A_input;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= S_FIX;
        end
        S_FIX: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          if (div_q) begin
            hi_q <= rem;
            lo_q <= quot;
          end else begin
            hi_q <= prod[2*WIDTH-1:WIDTH];
            lo_q <= prod[WIDTH-1:0];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign stall  = start & (busy_q | (state_q != S_IDLE));
  assign HI     = hi_q;
  assign LO     = lo_q;
  assign result = (op == OP_MFHI) ? hi_q : lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus stall/reset sequences.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A_input, B_input;
  logic        busy, done, stall;
  logic [31:0] HI, LO, result;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .A_input(A_input), .B_input(B_input),
    .busy(busy), .done(done), .stall(stall),
    .HI(HI), .LO(LO), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with busy high after the start edge; bounded.
  task automatic wait_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; A_input = a; B_input = b;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n, stall_bad, hold_bad;
    vecs[0] = '{3'b000, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{3'b010, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{3'b011, 32'd100,      32'h0,        32'h00000064, 32'hFFFFFFFF};
    vecs[4] = '{3'b010, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[5] = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6] = '{3'b010, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7] = '{3'b011, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    vecs[8] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[9] = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

    reset = 1'b1; start = 1'b0; op = 3'b000; A_input = '0; B_input = '0;
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    reset = 1'b0;
    tick();

    // Vector table: latency, done pulse, HI/LO
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_busy(n);
      chk($sformatf("v%0d_busy_cycles", i), n, 32'd33);
      chk($sformatf("v%0d_done", i), {31'b0, done}, 32'd1);
      chk($sformatf("v%0d_hi", i), HI, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), LO, vecs[i].lo);
      tick();
      chk($sformatf("v%0d_done_clr", i), {31'b0, done}, 32'd0);
    end

    // MTHI/MTLO and MFHI/MFLO
    issue(3'b110, 32'h12345678, 32'h0);
    chk("mthi_hi", HI, 32'h12345678);
    chk("mthi_busy", {31'b0, busy | done}, 32'd0);
    issue(3'b111, 32'hCAFEF00D, 32'h0);
    chk("mtlo_lo", LO, 32'hCAFEF00D);
    chk("mtlo_hi_kept", HI, 32'h12345678);
    start = 1'b1; op = 3'b100; #1;
    chk("mfhi_result", result, 32'h12345678);
    chk("mfhi_stall", {31'b0, stall}, 32'd0);
    op = 3'b101; #1;
    chk("mflo_result", result, 32'hCAFEF00D);
    tick();
    start = 1'b0;
    chk("mf_no_change", HI, 32'h12345678);

    // MFLO held during busy: stalls, HI/LO frozen, accepted in done cycle
    issue(3'b001, 32'd3, 32'd5);
    start = 1'b1; op = 3'b101;
    stall_bad = 0; hold_bad = 0; n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (stall !== 1'b1) stall_bad++;
      if (HI !== 32'h12345678 || LO !== 32'hCAFEF00D) hold_bad++;
      tick();
    end
    chk("mf_stall_cycles", n, 32'd33);
    chk("mf_stall_bad", stall_bad, 32'd0);
    chk("mf_hilo_hold_bad", hold_bad, 32'd0);
    chk("mf_done", {31'b0, done}, 32'd1);
    chk("mf_done_stall", {31'b0, stall}, 32'd0);
    chk("mf_done_result", result, 32'h0000000F);
    tick();
    start = 1'b0;

    // MULT re-presented while busy is started only once, at the done cycle
    issue(3'b000, 32'd2, 32'd3);
    start = 1'b1; op = 3'b000; A_input = 32'd4; B_input = 32'd5;
    wait_busy(n);
    chk("rep_first_cycles", n, 32'd33);
    chk("rep_first_lo", LO, 32'd6);
    chk("rep_done_stall", {31'b0, stall}, 32'd0);
    tick();
    start = 1'b0;
    wait_busy(n);
    chk("rep_second_cycles", n, 32'd33);
    chk("rep_second_lo", LO, 32'd20);
    tick();
    chk("rep_idle", {31'b0, busy}, 32'd0);

    // Reset mid-DIVU (counter at 10), then a clean MULTU
    issue(3'b110, 32'h12345678, 32'h0);
    issue(3'b011, 32'd1000, 32'd3);
    repeat (21) tick();
    chk("mid_busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b1; #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_hi", HI, 32'h0);
    chk("mid_rst_lo", LO, 32'h0);
    #1 reset = 1'b0;
    tick();
    issue(3'b001, 32'd2, 32'd2);
    wait_busy(n);
    chk("post_rst_cycles", n, 32'd33);
    chk("post_rst_lo", LO, 32'd4);
    chk("post_rst_hi", HI, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
